// File: rtl/fp_pkg.sv
// Shared floating-point widths, tag type and FSM states for the fp_mul sharing logic.
package fp_pkg;

    localparam int FP_EXP_W    = 8;
    localparam int FP_MNT_W    = 23;
    localparam int FP_DATA_W   = FP_EXP_W + FP_MNT_W + 1;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_MUL_LAT = 3;

    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int              c;
            logic [ID_W-1:0] cidx;
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cidx = c[ID_W-1:0];
            if (!found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one pipelined fp_mul among NUM_REQ requesters, with tag return path.
// Optional FP_MUL_ARB_CHECK_EN adds a sticky tag_err output comparing mul_out_valid to the tag head.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int I_EXP   = FP_EXP_W,
    parameter int I_MNT   = FP_MNT_W,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*I_DATA-1:0] req_a,
    input  logic [NUM_REQ*I_DATA-1:0] req_b,
    output logic                      mul_enable,
    output logic [I_DATA-1:0]         mul_a,
    output logic [I_DATA-1:0]         mul_b,
    input  logic [I_DATA-1:0]         mul_odata,
    input  logic                      mul_out_valid,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [I_DATA-1:0]         rsp_data,
`ifdef FP_MUL_ARB_CHECK_EN
    output logic                      tag_err,
`endif
    output logic                      busy
);

    // Operands are registered at the handshake edge and fp_mul samples them one edge
    // later, so the tag that lines up with out_valid sits MUL_LAT+1 stages downstream.
    localparam int STAGES = MUL_LAT + 2;
    localparam int CNT_W  = $clog2(MUL_LAT + 1);

    arb_state_e          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next, g_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                handshake;
    logic                mul_en_reg;
    logic [I_DATA-1:0]   mul_a_reg, mul_b_reg, a_next, b_next;
    logic [I_DATA-1:0]   a_arr [NUM_REQ];
    logic [I_DATA-1:0]   b_arr [NUM_REQ];
    mul_tag_t            tag_reg [STAGES];
    mul_tag_t            head;
    logic [STAGES-1:0]   tag_valids;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (g_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]     = req_a[gi*I_DATA +: I_DATA];
            assign b_arr[gi]     = req_b[gi*I_DATA +: I_DATA];
            assign rsp_valid[gi] = head.valid && (head.id == TAG_ID_W'(gi));
        end
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_valids
            assign tag_valids[gi] = tag_reg[gi].valid;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = '0;
        case (state_reg)
            FLUSH: begin
                if (cnt_reg == CNT_W'(MUL_LAT)) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN:     req_ready = grant;
            default: state_next = FLUSH;
        endcase
    end

    always_comb begin
        handshake = |(req_ready & req_valid);
        ptr_next  = ptr_reg;
        a_next    = '0;
        b_next    = '0;
        if (handshake) begin
            ptr_next = (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
            a_next   = a_arr[g_idx];
            b_next   = b_arr[g_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= FLUSH;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            mul_en_reg <= 1'b0;
            mul_a_reg  <= '0;
            mul_b_reg  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            mul_en_reg <= 1'b1;
            mul_a_reg  <= a_next;
            mul_b_reg  <= b_next;
            tag_reg[0] <= {handshake, TAG_ID_W'(g_idx)};
            for (int s = 1; s < STAGES; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    assign head       = tag_reg[STAGES-1];
    assign mul_enable = mul_en_reg;
    assign mul_a      = mul_a_reg;
    assign mul_b      = mul_b_reg;
    assign rsp_data   = mul_odata;
    assign busy       = (state_reg == FLUSH) || (|tag_valids);

`ifdef FP_MUL_ARB_CHECK_EN
    logic tag_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_err_reg <= 1'b0;
        end else if (state_reg == RUN && mul_out_valid != head.valid) begin
            tag_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_reg == RUN) begin
            assert (mul_out_valid == head.valid);
        end
    end

    assign tag_err = tag_err_reg;
`else
    logic unused_inputs;
    assign unused_inputs = mul_out_valid;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: behavioural fp_mul stand-in, arbitration model and scoreboard.
module tb_fp_mul_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 3;
    localparam int DW  = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid, req_ready, rsp_valid;
    logic [NR*DW-1:0]     req_a, req_b;
    logic                 mul_enable, mul_out_valid, busy;
    logic [DW-1:0]        mul_a, mul_b, mul_odata, rsp_data;
    logic                 tag_err;
    logic                 inject = 1'b0;

    always #5 clk = ~clk;

    fp_mul_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .mul_enable    (mul_enable),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_odata     (mul_odata),
        .mul_out_valid (mul_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
`ifdef FP_MUL_ARB_CHECK_EN
        .tag_err       (tag_err),
`endif
        .busy          (busy)
    );

`ifndef FP_MUL_ARB_CHECK_EN
    assign tag_err = 1'b0;
`endif

    // Normal-number single-precision multiply (truncating), used as the fp_mul stand-in.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        if (a == 0 || b == 0) return 32'h0;
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return {a[31] ^ b[31], 8'(e + 1), m[46:24]};
        return {a[31] ^ b[31], 8'(e), m[45:23]};
    endfunction

    // fp_mul stand-in: samples operands, result appears LAT edges after sampling.
    logic [DW-1:0] pd [LAT+1];
    logic          pv [LAT+1];
    always @(posedge clk) begin
        pv[0] <= mul_enable && (mul_a != 0 || mul_b != 0);
        pd[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k <= LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign mul_odata     = pd[LAT];
    assign mul_out_valid = pv[LAT] | inject;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_flush, m_ptr;
    bit            m_en;
    logic [31:0]   m_mula, m_mulb;
    exp_t          sb[$];
    int            gseq[$];
    logic [NR-1:0] rv, cont_mask, rsp_seen;
    logic [31:0]   ra [NR];
    logic [31:0]   rb [NR];
    bit            rnd_mode;
    int            last_hs_edge, last_rsp_cyc, first_rdy, t0;
    logic [31:0]   first_rsp [NR];
    bit            got_rsp [NR];

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = ra[i];
            req_b[i*DW +: DW] = rb[i];
        end
        req_valid = rv;
    endtask

    // One clock cycle: check outputs against the model, then advance the model and stimulus.
    task automatic tick();
        int            g;
        bit            hs;
        logic [NR-1:0] rdy_exp, rsp_exp;
        logic [31:0]   dat_exp;
        @(negedge clk);
        g = -1;
        if (m_flush == 0) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (g < 0 && rv[c]) g = c;
            end
        end
        rdy_exp = (g >= 0) ? NR'(1) << g : '0;
        while (sb.size() != 0 && sb[0].due < cyc) void'(sb.pop_front());
        rsp_exp = '0;
        dat_exp = '0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            rsp_exp = NR'(1) << sb[0].id;
            dat_exp = sb[0].data;
        end
        chk("req_ready", req_ready, rdy_exp);
        chk("rsp_valid", rsp_valid, rsp_exp);
        chk("busy", busy, (m_flush != 0) || (sb.size() != 0));
        chk("mul_enable", mul_enable, m_en);
        chk("mul_a", mul_a, m_mula);
        chk("mul_b", mul_b, m_mulb);
        if (rsp_exp != 0) chk("rsp_data", rsp_data, dat_exp);
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                gseq.push_back(i);
                if (first_rdy < 0) first_rdy = cyc;
                if (req_valid[i]) last_hs_edge = cyc + 1;
            end
            if (rsp_valid[i]) begin
                $display("rsp req%0d data %h cyc %0d", i, rsp_data, cyc);
                last_rsp_cyc = cyc;
                if (!got_rsp[i]) first_rsp[i] = rsp_data;
                got_rsp[i] = 1'b1;
            end
        end
        rsp_seen = rsp_seen | rsp_valid;
        @(posedge clk);
        cyc++;
        hs = (g >= 0) && !reset;
        if (reset) begin
            m_flush = LAT + 1;
            m_ptr   = 0;
            m_en    = 1'b0;
            m_mula  = '0;
            m_mulb  = '0;
            sb.delete();
        end else begin
            m_en = 1'b1;
            if (m_flush > 0) m_flush--;
            m_mula = hs ? ra[g] : '0;
            m_mulb = hs ? rb[g] : '0;
            if (hs) begin
                sb.push_back('{due: cyc + LAT + 1, id: g, data: fmul(ra[g], rb[g])});
                m_ptr = (g + 1) % NR;
            end
        end
        #1;
        if (hs) begin
            if (cont_mask[g]) begin
                ra[g] = rand_fp();
                rb[g] = rand_fp();
            end else begin
                rv[g] = 1'b0;
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = rand_fp();
                    rb[i] = rand_fp();
                end
            end
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 80 && (rv != 0 || sb.size() != 0); t++) tick();
        chk("drain_rv", rv, 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rv = '0;
        cont_mask = '0;
        rnd_mode = 1'b0;
        rsp_seen = '0;
        first_rdy = -1;
        last_hs_edge = -100;
        last_rsp_cyc = -200;
        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            got_rsp[i] = 1'b0;
            first_rsp[i] = '0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        m_flush = LAT + 1;
        m_ptr = 0;
        m_en = 1'b0;
        m_mula = '0;
        m_mulb = '0;

        // Reset state, then idle through the flush.
        tick();
        reset = 1'b0;
        first_rdy = -1;
        repeat (8) tick();
        chk("idle_busy", busy, 0);
        chk("idle_rsp", rsp_seen, 0);

        // Single request from requester 2: 1.5 * 2.0.
        rv[2] = 1'b1;
        ra[2] = 32'h3FC00000;
        rb[2] = 32'h40000000;
        drive();
        for (int t = 0; t < 20 && !got_rsp[2]; t++) tick();
        chk("single_data", first_rsp[2], 32'h40400000);
        chk("single_latency", 64'(last_rsp_cyc - last_hs_edge), 64'(LAT + 1));
        drain();

        // All four continuously from pointer 0.
        rv = '1;
        cont_mask = '1;
        for (int i = 0; i < NR; i++) begin
            ra[i] = rand_fp();
            rb[i] = rand_fp();
            got_rsp[i] = 1'b0;
        end
        ra[1] = 32'h40400000;
        rb[1] = 32'h40800000;
        drive();
        do_reset(2);
        gseq.delete();
        repeat (20) tick();
        chk("cont_count", gseq.size(), 16);
        for (int k = 0; k < 12; k++) chk("cont_order", gseq[k], k % NR);
        chk("cont_req1_product", first_rsp[1], 32'h41400000);
        cont_mask = '0;
        drain();

        // Sparse: only 1 and 3, alternating with no bubbles.
        rv = 4'b1010;
        cont_mask = 4'b1010;
        ra[1] = rand_fp(); rb[1] = rand_fp();
        ra[3] = rand_fp(); rb[3] = rand_fp();
        drive();
        gseq.delete();
        repeat (12) tick();
        chk("sparse_count", gseq.size(), 12);
        for (int k = 0; k < 8; k++) chk("sparse_order", gseq[k], (k % 2 == 0) ? 1 : 3);
        cont_mask = '0;
        drain();

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (60) tick();
        rnd_mode = 1'b0;
        drain();

        // Reset with three tags in flight.
        rv = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            ra[i] = rand_fp();
            rb[i] = rand_fp();
        end
        drive();
        repeat (3) tick();
        chk("inflight_busy", busy, 1);
        rv[3] = 1'b1;
        ra[3] = rand_fp();
        rb[3] = rand_fp();
        drive();
        do_reset(2);
        t0 = cyc;
        first_rdy = -1;
        rsp_seen = '0;
        repeat (12) tick();
        chk("discarded_rsp", rsp_seen & 4'b0111, 0);
        chk("first_grant_wait", 64'(first_rdy - t0), 64'(LAT + 1));
        drain();

`ifdef FP_MUL_ARB_CHECK_EN
        chk("tag_err_clean", tag_err, 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("tag_err_set", tag_err, 1);
        repeat (3) tick();
        chk("tag_err_sticky", tag_err, 1);
        do_reset(1);
        chk("tag_err_reset", tag_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
